// File: rtl/exc_redirect_ctrl.sv
// Exception entry / ERET / boot sequencer: samples WB exception flags, flushes the
// pipeline, issues CP0 update strobes and hands a redirect PC to fetch (valid/ready).
module exc_redirect_ctrl #(
  parameter logic [31:0] RESET_VEC = 32'hbfc0_0000,
  parameter logic [31:0] EXC_VEC   = 32'hbfc0_0380
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_valid,
  input  logic        wb_exc,
  input  logic [4:0]  wb_exccode,
  input  logic        wb_eret,
  input  logic [31:0] wb_pc,
  input  logic        wb_bd,
  input  logic        cp0_exl,
  input  logic [31:0] cp0_epc,
  output logic        pipe_flush,
  output logic        cp0_epc_we,
  output logic [31:0] cp0_epc_wdata,
  output logic        cp0_cause_we,
  output logic [4:0]  cp0_exccode,
  output logic        cp0_bd,
  output logic        cp0_set_exl,
  output logic        cp0_clr_exl,
  output logic        redir_valid,
  output logic [31:0] redir_pc,
  input  logic        redir_ready,
  output logic        busy
);

  typedef enum logic [1:0] {S_BOOT, S_IDLE, S_FLUSH, S_REDIR} state_e;

  state_e      state_q, state_d;
  logic        kind_q, kind_d;   // 1 = exception, 0 = ERET
  logic [31:0] pc_q, pc_d;
  logic [4:0]  code_q, code_d;
  logic        bd_q, bd_d;
  logic        exl_q, exl_d;
  logic [31:0] epc_q, epc_d;
  logic        evt;

  assign evt = wb_valid & (wb_exc | wb_eret);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_BOOT;
      kind_q  <= 1'b0;
      pc_q    <= 32'h0;
      code_q  <= 5'h0;
      bd_q    <= 1'b0;
      exl_q   <= 1'b0;
      epc_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      pc_q    <= pc_d;
      code_q  <= code_d;
      bd_q    <= bd_d;
      exl_q   <= exl_d;
      epc_q   <= epc_d;
    end
  end

  // Handshake: redir_valid stays high with a fixed redir_pc until a cycle with
  // redir_ready high; the transfer happens on that cycle's rising edge.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    pc_d    = pc_q;
    code_d  = code_q;
    bd_d    = bd_q;
    exl_d   = exl_q;
    epc_d   = epc_q;
    case (state_q)
      S_BOOT:  if (redir_ready) state_d = S_IDLE;
      S_IDLE: begin
        if (evt) begin
          state_d = S_FLUSH;
          kind_d  = wb_exc;
          pc_d    = wb_pc;
          code_d  = wb_exccode;
          bd_d    = wb_bd;
          exl_d   = cp0_exl;
          epc_d   = cp0_epc;
        end
      end
      S_FLUSH: state_d = S_REDIR;
      S_REDIR: if (redir_ready) state_d = S_IDLE;
      default: state_d = S_BOOT;
    endcase
  end

  always_comb begin
    pipe_flush    = 1'b1;
    cp0_epc_we    = 1'b0;
    cp0_epc_wdata = 32'h0;
    cp0_cause_we  = 1'b0;
    cp0_exccode   = 5'h0;
    cp0_bd        = 1'b0;
    cp0_set_exl   = 1'b0;
    cp0_clr_exl   = 1'b0;
    redir_valid   = 1'b0;
    redir_pc      = 32'h0;
    busy          = (state_q != S_IDLE);
    case (state_q)
      S_BOOT: begin
        // While reset is held the request is suppressed but the target is already presented.
        redir_valid = resetn;
        redir_pc    = RESET_VEC;
      end
      S_IDLE: pipe_flush = 1'b0;
      S_FLUSH: begin
        if (kind_q) begin
          cp0_cause_we = 1'b1;
          cp0_exccode  = code_q;
          cp0_set_exl  = 1'b1;
          if (!exl_q) begin
            // Nested exceptions keep the original EPC and BD.
            cp0_epc_we    = 1'b1;
            cp0_epc_wdata = bd_q ? (pc_q - 32'd4) : pc_q;
            cp0_bd        = bd_q;
          end
        end else begin
          cp0_clr_exl = 1'b1;
        end
      end
      S_REDIR: begin
        redir_valid = 1'b1;
        redir_pc    = kind_q ? EXC_VEC : epc_q;
      end
      default: ;
    endcase
  end

endmodule
